hub75_bcm_driver: RTL and testbench



---
 rtl/hub75_pkg.sv | 14 +
 rtl/hub75_bcm_driver_if.sv | 15 +
 rtl/hub75_line_buffer.sv | 63 ++++++
 rtl/hub75_bcm_driver.sv | 133 +++++++++++++
 tb/tb_hub75_bcm_driver.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM state codes, colour channel indices and line pixel-bit indexing
package hub75_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SHIFT   = 2'd1;
    localparam state_t ST_LATCH   = 2'd2;
    localparam state_t ST_DISPLAY = 2'd3;
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    function automatic int pix_bit(int p, int c, int b, int cbits);
        return (p * 3 + c) * cbits + b;
    endfunction
endpackage

// File: rtl/hub75_bcm_driver_if.sv
// hub75_bcm_driver_if: line source handshake (line_data0/1, line_addr, tvalid, tlast out of master; tready out of slave)
interface hub75_bcm_driver_if #(
    parameter int NUM_COLS   = 64,
    parameter int SCAN_RATE  = 32,
    parameter int COLOR_BITS = 3
);
    logic [NUM_COLS*3*COLOR_BITS-1:0] line_data0;
    logic [NUM_COLS*3*COLOR_BITS-1:0] line_data1;
    logic [$clog2(SCAN_RATE)-1:0]     line_addr;
    logic                             tvalid;
    logic                             tready;
    logic                             tlast;
    modport master (output line_data0, line_data1, line_addr, tvalid, tlast, input tready);
    modport slave  (input line_data0, line_data1, line_addr, tvalid, tlast, output tready);
endinterface

// File: rtl/hub75_line_buffer.sv
// hub75_line_buffer: shadow/active line registers; ports clk_in, rst_in, bus (slave), copy in, full/nxt0/nxt1/act_addr/act_last out
module hub75_line_buffer #(
    parameter int NUM_COLS   = 64,
    parameter int SCAN_RATE  = 32,
    parameter int COLOR_BITS = 3
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    hub75_bcm_driver_if.slave                bus,
    input  logic                             copy,
    output logic                             full,
    output logic [NUM_COLS*3*COLOR_BITS-1:0] nxt0,
    output logic [NUM_COLS*3*COLOR_BITS-1:0] nxt1,
    output logic [$clog2(SCAN_RATE)-1:0]     act_addr,
    output logic                             act_last
);
    localparam int DW = NUM_COLS * 3 * COLOR_BITS;
    localparam int AW = $clog2(SCAN_RATE);
    logic [DW-1:0] sh0_q, sh0_d, sh1_q, sh1_d, act0_q, act0_d, act1_q, act1_d;
    logic [AW-1:0] sh_addr_q, sh_addr_d, act_addr_q, act_addr_d;
    logic          sh_last_q, sh_last_d, act_last_q, act_last_d, full_q, full_d, load;
    always_comb begin
        load       = bus.tvalid && !full_q;
        sh0_d      = load ? bus.line_data0 : sh0_q;
        sh1_d      = load ? bus.line_data1 : sh1_q;
        sh_addr_d  = load ? bus.line_addr : sh_addr_q;
        sh_last_d  = load ? bus.tlast : sh_last_q;
        full_d     = load || (full_q && !copy);
        act0_d     = copy ? sh0_q : act0_q;
        act1_d     = copy ? sh1_q : act1_q;
        act_addr_d = copy ? sh_addr_q : act_addr_q;
        act_last_d = copy ? sh_last_q : act_last_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sh0_q      <= '0;
            sh1_q      <= '0;
            sh_addr_q  <= '0;
            sh_last_q  <= 1'b0;
            full_q     <= 1'b0;
            act0_q     <= '0;
            act1_q     <= '0;
            act_addr_q <= '0;
            act_last_q <= 1'b0;
        end else begin
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            sh_addr_q  <= sh_addr_d;
            sh_last_q  <= sh_last_d;
            full_q     <= full_d;
            act0_q     <= act0_d;
            act1_q     <= act1_d;
            act_addr_q <= act_addr_d;
            act_last_q <= act_last_d;
        end
    end
    assign bus.tready = !full_q;
    assign full       = full_q;
    assign nxt0       = act0_d;
    assign nxt1       = act1_d;
    assign act_addr   = act_addr_q;
    assign act_last   = act_last_q;
endmodule

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver: HUB75 BCM line driver; clk_in/rst_in, line source on bus (slave), registered pins rgb0/rgb1/led_addr/led_clk/led_latch/led_output_enable and frame_done
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int NUM_COLS    = 64,
    parameter int SCAN_RATE   = 32,
    parameter int COLOR_BITS  = 3,
    parameter int BASE_PERIOD = 10
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    hub75_bcm_driver_if.slave            bus,
    output logic [2:0]                   rgb0,
    output logic [2:0]                   rgb1,
    output logic [$clog2(SCAN_RATE)-1:0] led_addr,
    output logic                         led_clk,
    output logic                         led_latch,
    output logic                         led_output_enable,
    output logic                         frame_done
);
    localparam int DW  = NUM_COLS * 3 * COLOR_BITS;
    localparam int AW  = $clog2(SCAN_RATE);
    localparam int PW  = COLOR_BITS > 1 ? $clog2(COLOR_BITS) : 1;
    localparam int SW  = $clog2(2 * NUM_COLS);
    localparam int DCW = $clog2(BASE_PERIOD << (COLOR_BITS - 1)) + 1;
    localparam int CW  = SW > DCW ? SW : DCW;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * NUM_COLS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(COLOR_BITS - 1);
    localparam logic [CW-1:0] BASE       = CW'(BASE_PERIOD);
    localparam logic [DW-1:0] ONE        = DW'(1);
    state_t        state_q, state_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    logic [AW-1:0] addr_q, addr_d, act_addr;
    logic          lclk_q, lclk_d, latch_q, latch_d, oe_q, oe_d, done_q, done_d;
    logic          copy, full, act_last;
    logic [DW-1:0] nxt0, nxt1;
    int            pix, pl;
    hub75_line_buffer #(
        .NUM_COLS   (NUM_COLS),
        .SCAN_RATE  (SCAN_RATE),
        .COLOR_BITS (COLOR_BITS)
    ) u_buf (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bus      (bus),
        .copy     (copy),
        .full     (full),
        .nxt0     (nxt0),
        .nxt1     (nxt1),
        .act_addr (act_addr),
        .act_last (act_last)
    );
    function automatic logic pbit(logic [DW-1:0] d, int p, int c, int b);
        return |(d & (ONE << pix_bit(p, c, b, COLOR_BITS)));
    endfunction
    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        copy    = 1'b0;
        case (state_q)
            ST_IDLE: if (full) begin
                copy    = 1'b1;
                state_d = ST_SHIFT;
                plane_d = '0;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                state_d = cnt_q == SHIFT_LAST ? ST_LATCH : ST_SHIFT;
                cnt_d   = cnt_q == SHIFT_LAST ? '0 : cnt_q + CW'(1);
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                cnt_d   = '0;
            end
            ST_DISPLAY: if (cnt_q == (BASE << plane_q) - CW'(1)) begin
                cnt_d   = '0;
                state_d = plane_q == PLANE_LAST ? ST_IDLE : ST_SHIFT;
                plane_d = plane_q == PLANE_LAST ? plane_q : plane_q + PW'(1);
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        endcase
    end
    always_comb begin
        pix     = int'(cnt_d >> 1);
        pl      = int'(plane_d);
        oe_d    = state_d != ST_DISPLAY;
        latch_d = state_d == ST_LATCH;
        lclk_d  = state_d == ST_SHIFT && cnt_d[0];
        addr_d  = state_d == ST_LATCH ? act_addr : addr_q;
        done_d  = act_last && state_d == ST_DISPLAY && plane_d == PLANE_LAST &&
                  cnt_d == (BASE << plane_d) - CW'(1);
        rgb0_d  = state_d == ST_SHIFT ?
                  {pbit(nxt0, pix, CH_B, pl), pbit(nxt0, pix, CH_G, pl), pbit(nxt0, pix, CH_R, pl)} : 3'b0;
        rgb1_d  = state_d == ST_SHIFT ?
                  {pbit(nxt1, pix, CH_B, pl), pbit(nxt1, pix, CH_G, pl), pbit(nxt1, pix, CH_R, pl)} : 3'b0;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            plane_q <= '0;
            cnt_q   <= '0;
            rgb0_q  <= '0;
            rgb1_q  <= '0;
            addr_q  <= '0;
            lclk_q  <= 1'b0;
            latch_q <= 1'b0;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
            rgb0_q  <= rgb0_d;
            rgb1_q  <= rgb1_d;
            addr_q  <= addr_d;
            lclk_q  <= lclk_d;
            latch_q <= latch_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end
    assign rgb0              = rgb0_q;
    assign rgb1              = rgb1_q;
    assign led_addr          = addr_q;
    assign led_clk           = lclk_q;
    assign led_latch         = latch_q;
    assign led_output_enable = oe_q;
    assign frame_done        = done_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver: scoreboard bench for hub75_bcm_driver with 4 columns, 2 planes, base period 3
module tb_hub75_bcm_driver;
    localparam int NC     = 4;
    localparam int SR     = 32;
    localparam int CB     = 2;
    localparam int BP     = 3;
    localparam int DW     = NC * 3 * CB;
    localparam int AW     = 5;
    localparam int LINE_T = 1 + (2 * NC + 1 + BP) + (2 * NC + 1 + (BP << 1));
    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [AW-1:0] addr;
        logic          last;
    } line_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    rgb0, rgb1;
    logic [AW-1:0] led_addr;
    logic          led_clk, led_latch, led_oe, frame_done;
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    line_t         exp_q[$];
    int            lat_q[$];
    line_t         cur;
    logic [NC*3-1:0] cap0, cap1;
    int            bits, plane_m, oe_cnt, fd_cnt, fd_at, oe_bad, addr_bad, latches;
    logic          prev_clk, prev_oe;
    logic [AW-1:0] prev_addr;
    hub75_bcm_driver_if #(.NUM_COLS(NC), .SCAN_RATE(SR), .COLOR_BITS(CB)) bus ();
    hub75_bcm_driver #(
        .NUM_COLS    (NC),
        .SCAN_RATE   (SR),
        .COLOR_BITS  (CB),
        .BASE_PERIOD (BP)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .bus               (bus),
        .rgb0              (rgb0),
        .rgb1              (rgb1),
        .led_addr          (led_addr),
        .led_clk           (led_clk),
        .led_latch         (led_latch),
        .led_output_enable (led_oe),
        .frame_done        (frame_done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [NC*3-1:0] exp_bits(logic [DW-1:0] d, int p_l);
        logic [NC*3-1:0] r;
        for (int p = 0; p < NC; p++)
            for (int c = 0; c < 3; c++)
                r[p*3+c] = d[(p*3+c)*CB+p_l];
        return r;
    endfunction
    task automatic send(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [AW-1:0] a,
                        input logic l, output int hs);
        logic ok;
        int n;
        line_t e;
        bus.line_data0 = d0;
        bus.line_data1 = d1;
        bus.line_addr  = a;
        bus.tlast      = l;
        bus.tvalid     = 1'b1;
        ok = 1'b0;
        n  = 0;
        hs = 0;
        do begin
            ok = bus.tready;
            hs = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 500);
        bus.tvalid = 1'b0;
        if (ok) begin
            e.d0 = d0;
            e.d1 = d1;
            e.addr = a;
            e.last = l;
            exp_q.push_back(e);
        end else chk("handshake_timeout", 0, 1);
    endtask
    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("line_done_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask
    task automatic wait_oe_low();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led_oe && n < 200);
        chk("oe_low_timeout", led_oe, 0);
    endtask
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            plane_m = 0; bits = 0; cap0 = '0; cap1 = '0; oe_cnt = 0; fd_cnt = 0; fd_at = 0;
            oe_bad = 0; addr_bad = 0; latches = 0;
            prev_clk = 1'b0; prev_oe = 1'b1; prev_addr = '0;
        end else begin
            if (led_clk && !prev_clk) begin
                if (bits < NC) begin
                    cap0[bits*3 +: 3] = rgb0;
                    cap1[bits*3 +: 3] = rgb1;
                end
                bits++;
            end
            if (!led_oe && (led_clk || led_latch)) oe_bad++;
            if (led_addr != prev_addr && !led_latch) addr_bad++;
            if (!led_oe) oe_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = oe_cnt;
            end
            if (led_latch) begin
                latches++;
                lat_q.push_back(cyc);
                if (exp_q.size() == 0) chk("latch_unexpected", 1, 0);
                else begin
                    cur = exp_q[0];
                    chk("shift_count", bits, NC);
                    chk("rgb0_plane", cap0, exp_bits(cur.d0, plane_m));
                    chk("rgb1_plane", cap1, exp_bits(cur.d1, plane_m));
                    chk("latch_addr", led_addr, cur.addr);
                    chk("oe_high_shift_latch", oe_bad, 0);
                    chk("addr_only_on_latch", addr_bad, 0);
                end
                bits = 0; cap0 = '0; cap1 = '0; oe_cnt = 0;
            end
            if (led_oe && !prev_oe) begin
                if (exp_q.size() == 0) chk("display_unexpected", 1, 0);
                else begin
                    cur = exp_q[0];
                    chk("oe_low_len", oe_cnt, BP << plane_m);
                    if (plane_m == CB - 1) begin
                        chk("frame_done_cnt", fd_cnt, cur.last);
                        if (cur.last) chk("frame_done_at", fd_at, BP << (CB - 1));
                        void'(exp_q.pop_front());
                        plane_m = 0;
                        fd_cnt = 0;
                    end else plane_m++;
                end
            end
            prev_clk = led_clk;
            prev_oe = led_oe;
            prev_addr = led_addr;
        end
    end
    initial begin
        int ha, hb, rise, n;
        bus.tvalid = 1'b0;
        bus.tlast = 1'b0;
        bus.line_data0 = '0;
        bus.line_data1 = '0;
        bus.line_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_oe", led_oe, 1);
        chk("rst_tready", bus.tready, 1);
        chk("rst_pins", {rgb0, rgb1, led_addr, led_clk, led_latch, frame_done}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        lat_q.delete();
        send(DW'(3), '0, AW'(5), 1'b0, ha);
        wait_done();
        chk("latch_count_t1", lat_q.size(), 2);
        if (lat_q.size() >= 2) begin
            chk("latch0_cycle", lat_q[0] - ha, 2 + 2 * NC);
            chk("latch1_cycle", lat_q[1] - ha, 2 + 2 * NC + 1 + BP + 2 * NC);
        end
        chk("addr_after_line", led_addr, 5);
        lat_q.delete();
        send(DW'($urandom), DW'($urandom), AW'($urandom), 1'b0, ha);
        wait_oe_low();
        send(DW'($urandom), DW'($urandom), AW'($urandom), 1'b0, hb);
        @(negedge clk);
        chk("tready_low_after_hs", bus.tready, 0);
        n = 0;
        while (!bus.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        rise = cyc;
        chk("tready_rise", rise - ha, LINE_T + 2);
        wait_done();
        chk("latch_count_t2", lat_q.size(), 4);
        if (lat_q.size() >= 3) chk("b2b_latch", lat_q[2] - ha, LINE_T + 2 + 2 * NC);
        send(DW'($urandom), DW'($urandom), AW'($urandom), 1'b1, ha);
        wait_done();
        for (int i = 0; i < 3; i++)
            send(DW'($urandom), DW'($urandom), AW'(i * 7 + 3), i == 1, ha);
        wait_done();
        send(DW'($urandom), DW'($urandom), AW'(9), 1'b1, ha);
        send(DW'($urandom), DW'($urandom), AW'(17), 1'b1, hb);
        wait_oe_low();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("full_before_rst", bus.tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_oe", led_oe, 1);
        chk("mid_rst_tready", bus.tready, 1);
        chk("mid_rst_pins", {rgb0, rgb1, led_addr, led_clk, led_latch, frame_done}, 0);
        repeat (150) @(negedge clk);
        chk("discarded_never_shifted", latches, 0);
        chk("idle_oe_after_rst", led_oe, 1);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
